// File: rtl/out_wr_controller_fsm_pkg.sv
// Shared widths, state encodings, error codes and header field helpers for the
// output-side write controller. The input-side FSM uses the same definitions.
package out_wr_controller_fsm_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int PORT_NUB_TOTAL  = 16;
    localparam int DATA_LENGTH_MAX = 1024;
    localparam int WIDTH_SEL       = $clog2(PORT_NUB_TOTAL);
    localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX);
    localparam int HDR_TIMEOUT     = 64;
    localparam int WIDTH_TIMER     = $clog2(HDR_TIMEOUT);

    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_WAIT_HDR = 3'b001;
    localparam logic [2:0] ST_WR       = 3'b011;
    localparam logic [2:0] ST_DONE     = 3'b111;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_HDR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_HDR_LEN     = 2'b10;
    localparam logic [1:0] ERR_PROTOCOL    = 2'b11;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_SRC_LSB = WIDTH_LENGTH;

    function automatic logic [WIDTH_LENGTH-1:0] hdr_len(input logic [DATA_WIDTH-1:0] data);
        return data[HDR_LEN_LSB +: WIDTH_LENGTH];
    endfunction

endpackage

// File: rtl/out_wr_controller_fsm.sv
// Output-port write controller: grants a requesting input port once the FIFO can
// hold the whole frame, then writes its header and payload beats into the FIFO.
module out_wr_controller_fsm
    import out_wr_controller_fsm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [WIDTH_SEL-1:0]     req_src,
    input  logic [WIDTH_LENGTH-1:0]  req_length,
    output logic                     grant,
    output logic                     busy,
    input  logic                     in_valid,
    input  logic                     in_sel,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [WIDTH_LENGTH:0]    fifo_free,
    output logic                     fifo_wr_en,
    output logic [DATA_WIDTH-1:0]    fifo_wr_data,
    output logic                     frame_done,
    output logic [WIDTH_SEL-1:0]     frame_src,
    output logic [WIDTH_LENGTH-1:0]  frame_len,
    output logic                     err,
    output logic [1:0]               err_code
);

    logic [2:0]              r_state;
    logic [WIDTH_LENGTH-1:0] r_cnt;
    logic [WIDTH_TIMER-1:0]  r_timer;
    logic                    r_grant;
    logic                    r_busy;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_done;
    logic [WIDTH_SEL-1:0]    r_frame_src;
    logic [WIDTH_LENGTH-1:0] r_frame_len;
    logic                    r_err;
    logic [1:0]              r_err_code;

    logic [2:0]              w_next_state;
    logic [WIDTH_LENGTH-1:0] w_cnt;
    logic [WIDTH_LENGTH-1:0] w_cnt_inc;
    logic [WIDTH_TIMER-1:0]  w_timer;
    logic                    w_grant;
    logic                    w_wr_en;
    logic                    w_err;
    logic [1:0]              w_err_code;
    logic [WIDTH_SEL-1:0]    w_frame_src;
    logic [WIDTH_LENGTH-1:0] w_frame_len;
    logic [WIDTH_LENGTH:0]   w_need;
    logic                    w_room;

    // Room check is done one bit wider so a maximum-length request cannot wrap.
    assign w_need    = {1'b0, req_length} + {{WIDTH_LENGTH{1'b0}}, 1'b1};
    assign w_room    = (fifo_free >= w_need);
    assign w_cnt_inc = r_cnt + {{(WIDTH_LENGTH-1){1'b0}}, 1'b1};

    // Next-state, write-accept and error decode for the current beat.
    always_comb begin
        w_next_state = r_state;
        w_cnt        = r_cnt;
        w_timer      = r_timer;
        w_grant      = 1'b0;
        w_wr_en      = 1'b0;
        w_err        = 1'b0;
        w_err_code   = r_err_code;
        w_frame_src  = r_frame_src;
        w_frame_len  = r_frame_len;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_PROTOCOL;
                end else begin
                    w_err = 1'b0;
                end
                if (req && w_room) begin
                    w_grant      = 1'b1;
                    w_frame_src  = req_src;
                    w_frame_len  = req_length;
                    w_cnt        = {WIDTH_LENGTH{1'b0}};
                    w_timer      = {WIDTH_TIMER{1'b0}};
                    w_next_state = ST_WAIT_HDR;
                end else begin
                    w_grant = 1'b0;
                end
            end
            ST_WAIT_HDR: begin
                // A header arriving on the timeout cycle still wins.
                if (in_valid && in_sel) begin
                    w_wr_en      = 1'b1;
                    w_cnt        = {WIDTH_LENGTH{1'b0}};
                    w_next_state = (r_frame_len == {WIDTH_LENGTH{1'b0}}) ? ST_DONE : ST_WR;
                    if (hdr_len(in_data) != r_frame_len) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_HDR_LEN;
                    end else begin
                        w_err = 1'b0;
                    end
                end else if (r_timer == WIDTH_TIMER'(HDR_TIMEOUT - 1)) begin
                    w_err        = 1'b1;
                    w_err_code   = ERR_HDR_TIMEOUT;
                    w_next_state = ST_IDLE;
                end else begin
                    w_timer = r_timer + {{(WIDTH_TIMER-1){1'b0}}, 1'b1};
                    if (in_valid) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_PROTOCOL;
                    end else begin
                        w_err = 1'b0;
                    end
                end
            end
            ST_WR: begin
                if (in_valid && !in_sel) begin
                    w_wr_en = 1'b1;
                    w_cnt   = w_cnt_inc;
                    if (w_cnt_inc == r_frame_len) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WR;
                    end
                end else if (in_valid && in_sel) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_PROTOCOL;
                end else begin
                    w_err = 1'b0;
                end
            end
            ST_DONE: begin
                w_cnt        = {WIDTH_LENGTH{1'b0}};
                w_next_state = ST_IDLE;
                if (in_valid) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_PROTOCOL;
                end else begin
                    w_err = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt        = {WIDTH_LENGTH{1'b0}};
                w_timer      = {WIDTH_TIMER{1'b0}};
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {WIDTH_LENGTH{1'b0}};
            r_timer     <= {WIDTH_TIMER{1'b0}};
            r_grant     <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= {DATA_WIDTH{1'b0}};
            r_done      <= 1'b0;
            r_frame_src <= {WIDTH_SEL{1'b0}};
            r_frame_len <= {WIDTH_LENGTH{1'b0}};
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt;
            r_timer     <= w_timer;
            r_grant     <= w_grant;
            r_busy      <= (w_next_state != ST_IDLE);
            r_wr_en     <= w_wr_en;
            r_wr_data   <= w_wr_en ? in_data : r_wr_data;
            r_done      <= (w_next_state == ST_DONE);
            r_frame_src <= w_frame_src;
            r_frame_len <= w_frame_len;
            r_err       <= w_err;
            r_err_code  <= w_err_code;
        end
    end

    assign grant        = r_grant;
    assign busy         = r_busy;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign frame_done   = r_done;
    assign frame_src    = r_frame_src;
    assign frame_len    = r_frame_len;
    assign err          = r_err;
    assign err_code     = r_err_code;

endmodule
